clint: RTL and testbench
========================

Name: clint

Overview:
Wishbone B4 classic slave implementing the RISC-V machine timer and software-interrupt registers (mtime, mtimecmp, msip). It is the responder on the core's data-bus side, reached through the bus interconnect. It drives the core's xint_mtip_i and xint_msip_i inputs. The interconnect decodes the base address; this block decodes only wbs_addr_i[15:0].

Parameters:
TICK_DIV, 1, clock cycles per mtime increment; legal range 1..65535.
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
wbs_cyc_i  in  1  bus cycle valid
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  1=write, 0=read
wbs_sel_i  in  4  byte enables; bit n covers dat[8n+7:8n]
wbs_addr_i  in  32  byte address; only [15:0] decoded
wbs_dat_i  in  32  write data
wbs_dat_o  out  32  read data, valid while wbs_ack_o=1
wbs_ack_o  out  1  successful termination, one-cycle pulse
wbs_err_o  out  1  error termination, one-cycle pulse
xint_mtip_o  out  1  machine timer interrupt pending
xint_msip_o  out  1  machine software interrupt pending

Behaviour:
- Register map (offset = addr[15:0]): 0x0000 msip (bit0 RW, bits31:1 read 0, writes ignored); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Reset (rst_i=0 at a clock edge): mtime=0, mtimecmp=MTIMECMP_RST, msip=0, prescaler=0, FSM=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0. Reset overrides everything, including an in-flight response; ack/err are 0 the cycle after reset.
- FSM, two states:
  - IDLE: when wbs_cyc_i & wbs_stb_i, decode the access. Legal access = mapped offset and addr[1:0]==0. For a legal write, update the selected bytes at this edge; unselected bytes are kept. For a legal read, capture register contents as they were before this edge into wbs_dat_o. Go to RESP.
  - RESP: wbs_ack_o=1 for a legal access, or wbs_err_o=1 (with wbs_dat_o=0 and no side effects) for an illegal one. Exactly one cycle, then unconditionally IDLE.
- Latency: request seen at edge N gives ack/err high during cycle N+1. Back-to-back throughput is one transfer per 2 cycles. A request held high through RESP is re-serviced as a new request from IDLE.
- Master dropping cyc during RESP: the response still completes and any write has already committed. The master ignores the pulse.
- Prescaler: counts 0..TICK_DIV-1. A tick is generated on the edge where it wraps to 0. With TICK_DIV=1, mtime increments every cycle.
- mtime: increments by 1 on each tick, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF goes to 0). A bus write to either half of mtime on the same edge as a tick has priority: the written value is loaded, with no increment in either half on that edge. The prescaler is not reset by mtime writes.
- No atomic 64-bit read latch exists; software performs hi/lo/hi reads.
- xint_mtip_o = (mtime >= mtimecmp), 64-bit unsigned compare, combinational from registers. It changes in the same cycle the registers change.
- xint_msip_o = msip bit0.
- wbs_dat_o holds 0 when not in RESP.

Decomposition:
- Add to the shared defines.v:
  - `CLINT_MSIP 16'h0000, `CLINT_MTIMECMP_LO 16'h4000, `CLINT_MTIMECMP_HI 16'h4004, `CLINT_MTIME_LO 16'hBFF8, `CLINT_MTIME_HI 16'hBFFC.
  - FSM state encodings `CLINT_IDLE and `CLINT_RESP.
- One sub-module, clint_mtime. It holds the prescaler, the 64-bit counter with per-byte write/load priority, and the wrap logic.
- Top-level clint holds the Wishbone FSM, decode, mtimecmp, msip and the compare.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles, TICK_DIV=1, then release. Reads of 0xBFF8/0xBFFC/0x4000/0x4004/0x0000 return 0/0/0xFFFFFFFF/0xFFFFFFFF/0. mtip=0 and msip=0 throughout. Each ack arrives exactly 1 cycle after the request.
- Timer interrupt: TICK_DIV=4. Write mtimecmp_hi=0 and mtimecmp_lo=10. mtip rises in the cycle mtime becomes 10, i.e. 40 clocks after mtime was 0. Writing mtimecmp_lo=0xFFFFFFFF drops mtip the cycle after that write's edge.
- msip: write 0x0000=0xFFFFFFFF gives msip=1 and a readback of 0x00000001. Write 0 clears it.
- Byte enables: write mtimecmp_lo=0xAABBCCDD with sel=4'b0101 over the reset value. Readback is 0xFFBBFFDD.
- Errors: read 0x0004 and write 0x4002 each give err=1, ack=0, dat_o=0, and no register change.
- Wrap and priority: write mtime_hi=0xFFFFFFFF and mtime_lo=0xFFFFFFFE with TICK_DIV=1. Two cycles later mtime reads 0. A write of mtime_lo=5 on a tick edge reads back exactly 5 at the next edge; verify with a probe on the sub-module.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared definitions for the RISC-V core-local interruptor: the register map,
// the bus FSM states and the byte-lane merge used for partial writes.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  typedef enum logic [0:0] {
    CLINT_IDLE = 1'b0,
    CLINT_RESP = 1'b1
  } clint_state_t;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Wishbone B4 classic bus bundle between the interconnect (master) and the CLINT (slave).
interface clint_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/clint_mtime.sv
// Free-running 64-bit machine timer with a tick prescaler; a bus write to either
// half wins over a coincident tick and suppresses the increment on that edge.
module clint_mtime
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  logic [15:0] presc_r;
  logic [63:0] mtime_r;
  logic        tick_s;

  assign tick_s = (presc_r == PRESC_MAX);

  // Prescaler wraps to zero on the tick edge; mtime writes leave it alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      presc_r <= 16'd0;
    end else if (tick_s) begin
      presc_r <= 16'd0;
    end else begin
      presc_r <= presc_r + 16'd1;
    end
  end

  // Counter: bus load has priority over the tick increment.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mtime_r <= 64'd0;
    end else if (wr_lo) begin
      mtime_r[31:0] <= merge_bytes(mtime_r[31:0], wdata, sel);
    end else if (wr_hi) begin
      mtime_r[63:32] <= merge_bytes(mtime_r[63:32], wdata, sel);
    end else if (tick_s) begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  assign mtime = mtime_r;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: Wishbone slave exposing msip, mtimecmp and mtime, and
// driving the machine timer / software interrupt lines of the core.
module clint
  import clint_pkg::*;
#(
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  clint_if.slave wbs,
  output logic   xint_mtip_o,
  output logic   xint_msip_o
);

  clint_state_t state_r, state_nxt_s;
  logic [31:0]  dat_r, dat_nxt_s;
  logic         ack_r, ack_nxt_s;
  logic         err_r, err_nxt_s;
  logic [63:0]  mtimecmp_r;
  logic         msip_r;
  logic [63:0]  mtime_s;
  logic [15:0]  offset_s;
  logic         req_s, mapped_s, legal_s, wr_s;
  logic [31:0]  rd_data_s;
  logic         unused_s;

  assign offset_s = wbs.wbs_addr_i[15:0];
  assign unused_s = ^wbs.wbs_addr_i[31:16];
  assign req_s    = wbs.wbs_cyc_i & wbs.wbs_stb_i;

  // Address decode and read mux over the pre-edge register contents.
  always_comb begin
    mapped_s  = 1'b0;
    rd_data_s = 32'd0;
    case (offset_s)
      CLINT_MSIP:        begin mapped_s = 1'b1; rd_data_s = {31'd0, msip_r};    end
      CLINT_MTIMECMP_LO: begin mapped_s = 1'b1; rd_data_s = mtimecmp_r[31:0];  end
      CLINT_MTIMECMP_HI: begin mapped_s = 1'b1; rd_data_s = mtimecmp_r[63:32]; end
      CLINT_MTIME_LO:    begin mapped_s = 1'b1; rd_data_s = mtime_s[31:0];     end
      CLINT_MTIME_HI:    begin mapped_s = 1'b1; rd_data_s = mtime_s[63:32];    end
      default:           begin mapped_s = 1'b0; rd_data_s = 32'd0;             end
    endcase
    legal_s = mapped_s && (offset_s[1:0] == 2'b00);
  end

  // Bus FSM next state and the response to be registered.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    dat_nxt_s   = 32'd0;
    wr_s        = 1'b0;
    case (state_r)
      CLINT_IDLE: begin
        if (req_s) begin
          state_nxt_s = CLINT_RESP;
          ack_nxt_s   = legal_s;
          err_nxt_s   = !legal_s;
          wr_s        = legal_s && wbs.wbs_we_i;
          dat_nxt_s   = (legal_s && !wbs.wbs_we_i) ? rd_data_s : 32'd0;
        end else begin
          state_nxt_s = CLINT_IDLE;
        end
      end
      CLINT_RESP: state_nxt_s = CLINT_IDLE;
      default:    state_nxt_s = CLINT_IDLE;
    endcase
  end

  // FSM state and registered bus response.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= CLINT_IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      dat_r   <= dat_nxt_s;
    end
  end

  // Compare and software-interrupt registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mtimecmp_r <= MTIMECMP_RST;
      msip_r     <= 1'b0;
    end else if (wr_s) begin
      case (offset_s)
        CLINT_MSIP: begin
          if (wbs.wbs_sel_i[0]) msip_r <= wbs.wbs_dat_i[0];
        end
        CLINT_MTIMECMP_LO: mtimecmp_r[31:0]  <= merge_bytes(mtimecmp_r[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
        CLINT_MTIMECMP_HI: mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], wbs.wbs_dat_i, wbs.wbs_sel_i);
        default: begin end
      endcase
    end
  end

  clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wr_lo (wr_s && (offset_s == CLINT_MTIME_LO)),
    .wr_hi (wr_s && (offset_s == CLINT_MTIME_HI)),
    .sel   (wbs.wbs_sel_i),
    .wdata (wbs.wbs_dat_i),
    .mtime (mtime_s)
  );

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_err_o = err_r;
  assign wbs.wbs_dat_o = dat_r;
  assign xint_mtip_o   = (mtime_s >= mtimecmp_r);
  assign xint_msip_o   = msip_r;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: one instance with TICK_DIV=1 and one with TICK_DIV=4.
module tb_clint;
  import clint_pkg::*;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    bit          chk_dat;
  } exp_t;

  logic clk;
  logic rst_i;
  logic mtip1, msip1, mtip4, msip4;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  clint_if bus1 ();
  clint_if bus4 ();

  clint #(.TICK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .wbs(bus1), .xint_mtip_o(mtip1), .xint_msip_o(msip1)
  );

  clint #(.TICK_DIV(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .wbs(bus4), .xint_mtip_o(mtip4), .xint_msip_o(msip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic ack, input logic err, input logic [31:0] dat, input bit chk);
    exp_t e;
    e.ack = ack; e.err = err; e.dat = dat; e.chk_dat = chk;
    return e;
  endfunction

  task automatic drive(input bit d4, input logic cyc, input logic we, input logic [15:0] off,
                       input logic [31:0] wd, input logic [3:0] sel);
    if (d4) begin
      bus4.wbs_cyc_i = cyc; bus4.wbs_stb_i = cyc; bus4.wbs_we_i = we;
      bus4.wbs_sel_i = sel; bus4.wbs_addr_i = {16'h0200, off}; bus4.wbs_dat_i = wd;
    end else begin
      bus1.wbs_cyc_i = cyc; bus1.wbs_stb_i = cyc; bus1.wbs_we_i = we;
      bus1.wbs_sel_i = sel; bus1.wbs_addr_i = {16'h0200, off}; bus1.wbs_dat_i = wd;
    end
  endtask

  // Single transfer: request seen at one edge, response sampled mid next cycle.
  task automatic bus_xfer(input bit d4, input logic we, input logic [15:0] off, input logic [31:0] wd,
                          input logic [3:0] sel, output logic ack, output logic err, output logic [31:0] dat);
    @(negedge clk);
    drive(d4, 1'b1, we, off, wd, sel);
    @(posedge clk);
    #1;
    drive(d4, 1'b0, 1'b0, 16'h0000, 32'd0, 4'h0);
    @(negedge clk);
    if (d4) begin
      ack = bus4.wbs_ack_o; err = bus4.wbs_err_o; dat = bus4.wbs_dat_o;
    end else begin
      ack = bus1.wbs_ack_o; err = bus1.wbs_err_o; dat = bus1.wbs_dat_o;
    end
  endtask

  task automatic test_reset();
    logic [15:0] offs [5];
    logic [31:0] vals [5];
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    offs = '{CLINT_MTIME_LO, CLINT_MTIME_HI, CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI, CLINT_MSIP};
    vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'd0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'd0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({mtip1, msip1, bus1.wbs_ack_o, bus1.wbs_err_o, mtip4, msip4} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs: got mtip=%b msip=%b ack=%b err=%b, want all 0",
                 mtip1, msip1, bus1.wbs_ack_o, bus1.wbs_err_o);
      end
    end
    @(posedge clk);
    #1 rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(mk(1'b1, 1'b0, vals[i], 1'b1));
      bus_xfer(1'b0, 1'b0, offs[i], 32'd0, 4'hF, ack, err, dat);
      e = sb_q.pop_front();
      checks++;
      if (ack !== e.ack || err !== e.err || dat !== e.dat) begin
        failures++;
        $display("FAIL reset_read[%0h]: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                 offs[i], ack, err, dat, e.ack, e.err, e.dat);
      end
      checks++;
      if (mtip1 !== 1'b0 || msip1 !== 1'b0) begin
        failures++;
        $display("FAIL reset_irq: got mtip=%b msip=%b, want 0 0", mtip1, msip1);
      end
    end
  endtask

  task automatic test_timer();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    int t_one, rise;
    logic [15:0] offs [4];
    logic [31:0] vals [4];
    offs = '{CLINT_MTIMECMP_LO, CLINT_MTIMECMP_HI, CLINT_MTIME_HI, CLINT_MTIME_LO};
    vals = '{32'd10, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0));
      bus_xfer(1'b1, 1'b1, offs[i], vals[i], 4'hF, ack, err, dat);
      e = sb_q.pop_front();
      checks++;
      if (ack !== e.ack || err !== e.err) begin
        failures++;
        $display("FAIL timer_write[%0h]: got ack=%b err=%b, want ack=1 err=0", offs[i], ack, err);
      end
    end
    checks++;
    if (dut4.u_mtime.mtime_r !== 64'd0 || mtip4 !== 1'b0) begin
      failures++;
      $display("FAIL timer_zero: got mtime=%h mtip=%b, want 0 0", dut4.u_mtime.mtime_r, mtip4);
    end
    t_one = -1;
    rise  = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (dut4.u_mtime.mtime_r == 64'd1 && t_one < 0) t_one = c;
      if (mtip4 === 1'b1) begin
        rise = c;
        break;
      end
    end
    checks++;
    if (rise < 0 || dut4.u_mtime.mtime_r !== 64'd10) begin
      failures++;
      $display("FAIL timer_rise: got rise_cycle=%0d mtime=%0d, want rise with mtime=10", rise, dut4.u_mtime.mtime_r);
    end
    checks++;
    if (t_one < 1 || t_one > 4 || (rise - t_one) != 36) begin
      failures++;
      $display("FAIL timer_period: got first_tick=%0d ticks_1_to_10=%0d cycles, want 1..4 and 36", t_one, rise - t_one);
    end
    sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0));
    bus_xfer(1'b1, 1'b1, CLINT_MTIMECMP_LO, 32'hFFFF_FFFF, 4'hF, ack, err, dat);
    e = sb_q.pop_front();
    checks++;
    if (ack !== e.ack || err !== e.err || mtip4 !== 1'b0) begin
      failures++;
      $display("FAIL timer_drop: got ack=%b err=%b mtip=%b, want 1 0 0", ack, err, mtip4);
    end
  endtask

  task automatic test_msip();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    logic [31:0] wvals [2];
    wvals = '{32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0));
      bus_xfer(1'b0, 1'b1, CLINT_MSIP, wvals[i], 4'hF, ack, err, dat);
      e = sb_q.pop_front();
      checks++;
      if (ack !== e.ack || err !== e.err || msip1 !== wvals[i][0]) begin
        failures++;
        $display("FAIL msip_write[%0d]: got ack=%b err=%b msip=%b, want 1 0 %b", i, ack, err, msip1, wvals[i][0]);
      end
      sb_q.push_back(mk(1'b1, 1'b0, {31'd0, wvals[i][0]}, 1'b1));
      bus_xfer(1'b0, 1'b0, CLINT_MSIP, 32'd0, 4'hF, ack, err, dat);
      e = sb_q.pop_front();
      checks++;
      if (ack !== e.ack || err !== e.err || dat !== e.dat) begin
        failures++;
        $display("FAIL msip_read[%0d]: got ack=%b err=%b dat=%h, want 1 0 %h", i, ack, err, dat, e.dat);
      end
    end
  endtask

  task automatic test_byte_enables();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0));
    bus_xfer(1'b0, 1'b1, CLINT_MTIMECMP_LO, 32'hAABB_CCDD, 4'b0101, ack, err, dat);
    e = sb_q.pop_front();
    checks++;
    if (ack !== e.ack || err !== e.err) begin
      failures++;
      $display("FAIL sel_write: got ack=%b err=%b, want 1 0", ack, err);
    end
    sb_q.push_back(mk(1'b1, 1'b0, 32'hFFBB_FFDD, 1'b1));
    bus_xfer(1'b0, 1'b0, CLINT_MTIMECMP_LO, 32'd0, 4'hF, ack, err, dat);
    e = sb_q.pop_front();
    checks++;
    if (ack !== e.ack || err !== e.err || dat !== e.dat) begin
      failures++;
      $display("FAIL sel_read: got ack=%b err=%b dat=%h, want 1 0 %h", ack, err, dat, e.dat);
    end
  endtask

  task automatic test_errors();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    logic [15:0] offs [6];
    logic        wes  [6];
    offs = '{16'h0004, 16'h4002, 16'hBFF9, 16'h0001, CLINT_MTIMECMP_LO, CLINT_MSIP};
    wes  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(1'b0, 1'b1, 32'd0, 1'b1));
    sb_q.push_back(mk(1'b1, 1'b0, 32'hFFBB_FFDD, 1'b1));
    sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      bus_xfer(1'b0, wes[i], offs[i], 32'h1234_5679, 4'hF, ack, err, dat);
      e = sb_q.pop_front();
      checks++;
      if (ack !== e.ack || err !== e.err || dat !== e.dat) begin
        failures++;
        $display("FAIL err_access[%0h]: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                 offs[i], ack, err, dat, e.ack, e.err, e.dat);
      end
    end
    checks++;
    if (msip1 !== 1'b0) begin
      failures++;
      $display("FAIL err_no_effect: got msip=%b, want 0", msip1);
    end
  endtask

  task automatic test_wrap();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    logic [63:0] cmp_model;
    logic [63:0] exp_mt [3];
    cmp_model = 64'hFFFF_FFFF_FFBB_FFDD;
    exp_mt = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    sb_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0));
    bus_xfer(1'b0, 1'b1, CLINT_MTIME_HI, 32'hFFFF_FFFF, 4'hF, ack, err, dat);
    e = sb_q.pop_front();
    checks++;
    if (ack !== e.ack || err !== e.err) begin
      failures++;
      $display("FAIL wrap_write_hi: got ack=%b err=%b, want 1 0", ack, err);
    end
    bus_xfer(1'b0, 1'b1, CLINT_MTIME_LO, 32'hFFFF_FFFE, 4'hF, ack, err, dat);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (dut1.u_mtime.mtime_r !== exp_mt[i] || mtip1 !== (exp_mt[i] >= cmp_model)) begin
        failures++;
        $display("FAIL wrap_step[%0d]: got mtime=%h mtip=%b, want %h %b",
                 i, dut1.u_mtime.mtime_r, mtip1, exp_mt[i], exp_mt[i] >= cmp_model);
      end
    end
    bus_xfer(1'b0, 1'b1, CLINT_MTIME_LO, 32'd5, 4'hF, ack, err, dat);
    checks++;
    if (dut1.u_mtime.mtime_r !== 64'd5) begin
      failures++;
      $display("FAIL write_priority: got mtime=%h, want 5", dut1.u_mtime.mtime_r);
    end
    @(negedge clk);
    checks++;
    if (dut1.u_mtime.mtime_r !== 64'd6) begin
      failures++;
      $display("FAIL tick_after_write: got mtime=%h, want 6", dut1.u_mtime.mtime_r);
    end
  endtask

  task automatic test_back_to_back();
    logic ack, err;
    logic [31:0] dat;
    exp_t e;
    bus_xfer(1'b0, 1'b1, CLINT_MSIP, 32'd1, 4'h1, ack, err, dat);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, CLINT_MSIP, 32'd0, 4'hF);
    for (int k = 0; k < 4; k++) sb_q.push_back(mk(k[0] ? 1'b0 : 1'b1, 1'b0, k[0] ? 32'd0 : 32'd1, 1'b1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (bus1.wbs_ack_o !== e.ack || bus1.wbs_err_o !== e.err || bus1.wbs_dat_o !== e.dat) begin
        failures++;
        $display("FAIL b2b[%0d]: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                 k, bus1.wbs_ack_o, bus1.wbs_err_o, bus1.wbs_dat_o, e.ack, e.err, e.dat);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'd0, 4'h0);
    @(negedge clk);
    checks++;
    if (bus1.wbs_ack_o !== 1'b0 || bus1.wbs_dat_o !== 32'd0) begin
      failures++;
      $display("FAIL idle_quiet: got ack=%b dat=%h, want 0 0", bus1.wbs_ack_o, bus1.wbs_dat_o);
    end
  endtask

  task automatic test_reset_override();
    exp_t e;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, CLINT_MSIP, 32'd0, 4'hF);
    rst_i = 1'b0;
    sb_q.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1));
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 16'h0, 32'd0, 4'h0);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (bus1.wbs_ack_o !== e.ack || bus1.wbs_err_o !== e.err || bus1.wbs_dat_o !== e.dat ||
        msip1 !== 1'b0 || dut1.u_mtime.mtime_r !== 64'd0) begin
      failures++;
      $display("FAIL reset_override: got ack=%b err=%b dat=%h msip=%b mtime=%h, want all 0",
               bus1.wbs_ack_o, bus1.wbs_err_o, bus1.wbs_dat_o, msip1, dut1.u_mtime.mtime_r);
    end
    rst_i = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_timer();
    test_msip();
    test_byte_enables();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_override();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
